// File: rtl/bitwise_sweep_ctrl_pkg.sv
// Shared types for the bitwise datapath self-check sequencer: FSM state
// encoding, the 5-bit result bundle and the reference model of the datapath.
package bitwise_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  localparam int unsigned RES_W = 5;

  // Bundle order, MSB first: {a_xor_b, a_or_b, a_and_b, b_inv, a_inv}
  typedef struct packed {
    logic a_xor_b;
    logic a_or_b;
    logic a_and_b;
    logic b_inv;
    logic a_inv;
  } res_t;

  function automatic res_t expected_res(input logic a, input logic b);
    res_t r;
    r.a_xor_b = a ^ b;
    r.a_or_b  = a | b;
    r.a_and_b = a & b;
    r.b_inv   = ~b;
    r.a_inv   = ~a;
    return r;
  endfunction

endpackage

// File: rtl/bitwise_sweep_ctrl_check.sv
// Combinational comparator: checks an observed result bundle against the
// reference model for operands a/b. The observed bundle is passed back out
// only when failure logging (BITWISE_SWEEP_LOG_EN) is built in.
module bitwise_check
  import bitwise_pkg::*;
(
  input  logic             a,
  input  logic             b,
  input  logic [RES_W-1:0] obs,
  output logic             mismatch
`ifdef BITWISE_SWEEP_LOG_EN
  ,
  output logic [RES_W-1:0] obs_res
`endif
);

  res_t exp_res;

  // Any differing bit in the bundle marks the whole vector as failing
  always_comb begin
    exp_res  = expected_res(a, b);
    mismatch = (obs != exp_res);
`ifdef BITWISE_SWEEP_LOG_EN
    obs_res  = obs;
`endif
  end

endmodule

// File: rtl/bitwise_sweep_ctrl.sv
// Self-check sequencer for the 1-bit bitwise datapath. Sweeps a/b through
// 00,01,10,11 for N_PASSES passes, waits SETTLE_CYCLES per vector, compares
// the results and reports pass/err_cnt via a four-phase start/done handshake.
// Optional first-failure log ports: define BITWISE_SWEEP_LOG_EN.
module bitwise_sweep_ctrl
  import bitwise_pkg::*;
#(
  parameter int unsigned N_PASSES      = 1,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             a_inv,
  input  logic             b_inv,
  input  logic             a_and_b,
  input  logic             a_or_b,
  input  logic             a_xor_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef BITWISE_SWEEP_LOG_EN
  ,
  output logic             fail_vld,
  output logic [1:0]       fail_idx,
  output logic [RES_W-1:0] fail_res
`endif
);

  localparam int unsigned PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [PW-1:0] LAST_PASS   = PW'(N_PASSES - 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       idx_q, idx_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [SW-1:0]    scnt_q, scnt_d;

  logic [RES_W-1:0] obs;
  logic             mismatch;
  logic             err_inc;
  logic [ERR_W-1:0] err_next;

`ifdef BITWISE_SWEEP_LOG_EN
  logic             fail_vld_q, fail_vld_d;
  logic [1:0]       fail_idx_q, fail_idx_d;
  logic [RES_W-1:0] fail_res_q, fail_res_d;
  logic [RES_W-1:0] chk_res;
`endif

  assign obs = {a_xor_b, a_or_b, a_and_b, b_inv, a_inv};

  bitwise_check u_check (
    .a        (a_q),
    .b        (b_q),
    .obs      (obs),
    .mismatch (mismatch)
`ifdef BITWISE_SWEEP_LOG_EN
    ,
    .obs_res  (chk_res)
`endif
  );

  // Next-state and registered-output logic for the sweep FSM
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    idx_d    = idx_q;
    pcnt_d   = pcnt_q;
    scnt_d   = scnt_q;
    err_inc  = mismatch && (err_q != '1);
    err_next = err_q + ERR_W'(err_inc);
`ifdef BITWISE_SWEEP_LOG_EN
    fail_vld_d = fail_vld_q;
    fail_idx_d = fail_idx_q;
    fail_res_d = fail_res_q;
`endif

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          state_d = APPLY;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          idx_d   = '0;
          pcnt_d  = '0;
          scnt_d  = '0;
`ifdef BITWISE_SWEEP_LOG_EN
          fail_vld_d = 1'b0;
          fail_idx_d = '0;
          fail_res_d = '0;
`endif
        end
      end

      APPLY: begin
        a_d     = idx_q[1];
        b_d     = idx_q[0];
        scnt_d  = SETTLE_INIT;
        state_d = SETTLE;
      end

      SETTLE: begin
        if (scnt_q == '0) begin
          state_d = CHECK;
        end else begin
          scnt_d = scnt_q - SW'(1);
        end
      end

      CHECK: begin
        err_d = err_next;
`ifdef BITWISE_SWEEP_LOG_EN
        if (mismatch && !fail_vld_q) begin
          fail_vld_d = 1'b1;
          fail_idx_d = idx_q;
          fail_res_d = chk_res;
        end
`endif
        if ((idx_q == 2'd3) && (pcnt_q == LAST_PASS)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end else begin
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            pcnt_d = pcnt_q + PW'(1);
          end
          state_d = APPLY;
        end
      end

      DONE: begin
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      idx_q   <= '0;
      pcnt_q  <= '0;
      scnt_q  <= '0;
`ifdef BITWISE_SWEEP_LOG_EN
      fail_vld_q <= 1'b0;
      fail_idx_q <= '0;
      fail_res_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
`ifdef BITWISE_SWEEP_LOG_EN
      fail_vld_q <= fail_vld_d;
      fail_idx_q <= fail_idx_d;
      fail_res_q <= fail_res_d;
`endif
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
`ifdef BITWISE_SWEEP_LOG_EN
  assign fail_vld = fail_vld_q;
  assign fail_idx = fail_idx_q;
  assign fail_res = fail_res_q;
`endif

endmodule

// File: tb/tb_bitwise_sweep_ctrl.sv
// Directed bench for bitwise_sweep_ctrl. Three instances with different
// parameters each drive a behavioural datapath with a selectable fault.
// fault 0: correct, 1: a_xor_b stuck at 0, 2: a_inv inverted.
module tb_bitwise_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n_v, start_v, a_v, b_v, busy_v, done_v, pass_v;
  logic [2:0] ainv_v, binv_v, and_v, or_v, xor_v;
  logic [1:0] fault_v [3];
  logic [7:0] err0, err1;
  logic [1:0] err2;

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dp
    assign ainv_v[g] = ~a_v[g] ^ (fault_v[g] == 2'd2);
    assign binv_v[g] = ~b_v[g];
    assign and_v[g]  = a_v[g] & b_v[g];
    assign or_v[g]   = a_v[g] | b_v[g];
    assign xor_v[g]  = (fault_v[g] == 2'd1) ? 1'b0 : (a_v[g] ^ b_v[g]);
  end

`ifdef BITWISE_SWEEP_LOG_EN
  logic [2:0] fvld_v;
  logic [1:0] fidx_v [3];
  logic [4:0] fres_v [3];
`endif

  bitwise_sweep_ctrl #(.N_PASSES(1), .SETTLE_CYCLES(1), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .a_inv(ainv_v[0]), .b_inv(binv_v[0]), .a_and_b(and_v[0]), .a_or_b(or_v[0]),
    .a_xor_b(xor_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_cnt(err0)
`ifdef BITWISE_SWEEP_LOG_EN
    , .fail_vld(fvld_v[0]), .fail_idx(fidx_v[0]), .fail_res(fres_v[0])
`endif
  );

  bitwise_sweep_ctrl #(.N_PASSES(2), .SETTLE_CYCLES(2), .ERR_W(8)) u_b (
    .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .a_inv(ainv_v[1]), .b_inv(binv_v[1]), .a_and_b(and_v[1]), .a_or_b(or_v[1]),
    .a_xor_b(xor_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_cnt(err1)
`ifdef BITWISE_SWEEP_LOG_EN
    , .fail_vld(fvld_v[1]), .fail_idx(fidx_v[1]), .fail_res(fres_v[1])
`endif
  );

  bitwise_sweep_ctrl #(.N_PASSES(2), .SETTLE_CYCLES(1), .ERR_W(2)) u_c (
    .clk(clk), .rst_n(rst_n_v[2]), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .a_inv(ainv_v[2]), .b_inv(binv_v[2]), .a_and_b(and_v[2]), .a_or_b(or_v[2]),
    .a_xor_b(xor_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_cnt(err2)
`ifdef BITWISE_SWEEP_LOG_EN
    , .fail_vld(fvld_v[2]), .fail_idx(fidx_v[2]), .fail_res(fres_v[2])
`endif
  );

  function automatic logic [7:0] get_err(input int i);
    case (i)
      0:       return err0;
      1:       return err1;
      default: return {6'b0, err2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise start on instance i and follow the run to done. Vector operands are
  // checked in each CHECK cycle (edges S+1+k*(S+2) after the start edge).
  task automatic run(input string nm, input int i, input int s_cyc,
                     input int exp_lat, input bit hold);
    int n;
    int vcnt;
    int per;
    per = s_cyc + 2;
    start_v[i] = 1'b1;
    @(negedge clk);
    chk({nm, "_busy_on_start"}, busy_v[i], 1);
    chk({nm, "_done_lo_on_start"}, done_v[i], 0);
    chk({nm, "_err_cleared"}, get_err(i), 0);
    if (!hold) start_v[i] = 1'b0;
    n = 0;
    vcnt = 0;
    while (done_v[i] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (n >= s_cyc + 1 && ((n - s_cyc - 1) % per) == 0) begin
        chk({nm, "_vec_ab"}, {a_v[i], b_v[i]}, vcnt % 4);
        chk({nm, "_vec_busy"}, busy_v[i], 1);
        vcnt++;
      end
    end
    chk({nm, "_latency"}, n, exp_lat);
    chk({nm, "_vec_count"}, vcnt, exp_lat / per);
    chk({nm, "_done_busy_lo"}, busy_v[i], 0);
    chk({nm, "_done_ab_11"}, {a_v[i], b_v[i]}, 2'b11);
  endtask

  initial begin
    int seen;
    rst_n_v = 3'b000;
    start_v = 3'b000;
    for (int i = 0; i < 3; i++) fault_v[i] = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_v, 3'b000);
    chk("rst_done", done_v, 3'b000);
    chk("rst_pass", pass_v, 3'b000);
    chk("rst_a", a_v, 3'b000);
    chk("rst_b", b_v, 3'b000);
    chk("rst_err0", err0, 0);
    chk("rst_err2", err2, 0);
    rst_n_v = 3'b111;
    @(negedge clk);

    // Clean run, then start held high after done
    run("clean", 0, 1, 12, 1'b1);
    chk("clean_pass", pass_v[0], 1);
    chk("clean_err", err0, 0);
    repeat (3) @(negedge clk);
    chk("hold_done", done_v[0], 1);
    chk("hold_busy", busy_v[0], 0);
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("drop_done", done_v[0], 0);
    chk("drop_busy", busy_v[0], 0);
    chk("idle_pass_hold", pass_v[0], 1);

    // a_xor_b stuck at 0, single pass: vectors 01 and 10 fail
    fault_v[0] = 2'd1;
    run("xor1", 0, 1, 12, 1'b1);
    chk("xor1_err", err0, 2);
    chk("xor1_pass", pass_v[0], 0);
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("xor1_idle_err_hold", err0, 2);
    chk("xor1_idle_pass_hold", pass_v[0], 0);

    // Re-run clean: err_cnt cleared at start
    fault_v[0] = 2'd0;
    run("rerun", 0, 1, 12, 1'b1);
    chk("rerun_err", err0, 0);
    chk("rerun_pass", pass_v[0], 1);
    start_v[0] = 1'b0;
    @(negedge clk);

    // a_xor_b stuck at 0, two passes, settle 2: four failing vectors
    fault_v[1] = 2'd1;
    run("xor2", 1, 2, 32, 1'b1);
    chk("xor2_err", err1, 4);
    chk("xor2_pass", pass_v[1], 0);
`ifdef BITWISE_SWEEP_LOG_EN
    chk("xor2_fail_vld", fvld_v[1], 1);
    chk("xor2_fail_idx", fidx_v[1], 1);
    chk("xor2_fail_res", fres_v[1], 5'b01001);
`endif
    start_v[1] = 1'b0;
    @(negedge clk);

    // Every vector corrupt, two passes, 2-bit counter saturates at 3
    fault_v[2] = 2'd2;
    run("sat", 2, 1, 24, 1'b1);
    chk("sat_err", err2, 3);
    chk("sat_pass", pass_v[2], 0);
    start_v[2] = 1'b0;
    @(negedge clk);

    // Reset during SETTLE of vector 2 (7 edges after the start edge)
    fault_v[0] = 2'd1;
    start_v[0] = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_ab", {a_v[0], b_v[0]}, 2'b10);
    chk("mid_busy", busy_v[0], 1);
    chk("mid_err", err0, 1);
    rst_n_v[0] = 1'b0;
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy_v[0], 0);
    chk("abort_ab", {a_v[0], b_v[0]}, 2'b00);
    chk("abort_err", err0, 0);
    chk("abort_done", done_v[0], 0);
    rst_n_v[0] = 1'b1;
    fault_v[0] = 2'd0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    run("after_abort", 0, 1, 12, 1'b1);
    chk("after_abort_pass", pass_v[0], 1);
    start_v[0] = 1'b0;
    @(negedge clk);

    // Single-cycle start pulse: run completes, done lasts one cycle
    run("pulse", 0, 1, 12, 1'b0);
    chk("pulse_done", done_v[0], 1);
    chk("pulse_pass", pass_v[0], 1);
    @(negedge clk);
    chk("pulse_done_drop", done_v[0], 0);
    chk("pulse_idle_busy", busy_v[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
